enigma_stream: RTL and testbench



---
 rtl/enigma_stream.sv | 135 +++++++++++++
 tb/tb_enigma_stream.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/enigma_stream.sv
// Streaming modified-Enigma cipher: NUM_ROTORS odometer-stepped affine rotors
// around a fixed reflector, valid/ready on both sides, one-cycle latency.
module enigma_stream #(
  parameter int NUM_ROTORS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [5*NUM_ROTORS-1:0] load_pos,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              in_char,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              out_char,
  output logic [5*NUM_ROTORS-1:0] pos
);

  localparam int PW = 5 * NUM_ROTORS;

  logic [PW-1:0] pos_q, pos_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_char_q, out_char_d;

  function automatic int a_of(input int i);
    case (i)
      0: return 3;   1: return 5;   2: return 7;   3: return 9;
      4: return 11;  5: return 15;  6: return 17;  default: return 19;
    endcase
  endfunction

  function automatic int ainv_of(input int i);
    case (i)
      0: return 9;   1: return 21;  2: return 15;  3: return 3;
      4: return 19;  5: return 7;   6: return 23;  default: return 11;
    endcase
  endfunction

  // Offsets of +26 keep every intermediate non-negative before the final mod.
  function automatic logic [4:0] encrypt(input logic [4:0] x, input logic [PW-1:0] p);
    int v;
    int pi;
    v = int'(x);
    for (int i = 0; i < NUM_ROTORS; i++) begin
      pi = int'(p[5*i +: 5]);
      v  = (a_of(i) * ((v + pi) % 26) + i + 27 - pi) % 26;
    end
    v = 25 - v;
    for (int i = NUM_ROTORS - 1; i >= 0; i--) begin
      pi = int'(p[5*i +: 5]);
      v  = (ainv_of(i) * (((v + pi) % 26) + 25 - i) + 26 - pi) % 26;
    end
    return 5'(v);
  endfunction

  function automatic logic [PW-1:0] step_pos(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    logic          carry;
    r     = p;
    carry = 1'b1;
    for (int i = 0; i < NUM_ROTORS; i++) begin
      if (carry) begin
        if (p[5*i +: 5] == 5'd25) begin
          r[5*i +: 5] = 5'd0;
        end else begin
          r[5*i +: 5] = p[5*i +: 5] + 5'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] sanitize(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    r = p;
    for (int i = 0; i < NUM_ROTORS; i++) begin
      if (p[5*i +: 5] >= 5'd26) r[5*i +: 5] = p[5*i +: 5] - 5'd26;
    end
    return r;
  endfunction

  logic          is_letter;
  logic [4:0]    letter_idx;
  logic [4:0]    cipher_idx;
  logic [PW-1:0] pos_stepped;
  logic          accept;

  // 'A' and 'a' both have 5'b00001 in their low bits, so the letter index is
  // in_char[4:0]-1 for either case and the upper three bits carry the case.
  assign is_letter   = ((in_char >= 8'h41) && (in_char <= 8'h5A)) ||
                       ((in_char >= 8'h61) && (in_char <= 8'h7A));
  assign letter_idx  = in_char[4:0] - 5'd1;
  assign pos_stepped = step_pos(pos_q);
  assign cipher_idx  = encrypt(letter_idx, pos_stepped);

  assign in_ready = !load && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    pos_d       = pos_q;
    out_valid_d = out_valid_q;
    out_char_d  = out_char_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (load) begin
      pos_d = sanitize(load_pos);
    end else if (accept) begin
      out_valid_d = 1'b1;
      if (is_letter) begin
        pos_d      = pos_stepped;
        out_char_d = {in_char[7:5], cipher_idx + 5'd1};
      end else begin
        out_char_d = in_char;
      end
    end
  end

  // Output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q       <= '0;
      out_valid_q <= 1'b0;
      out_char_q  <= 8'h00;
    end else begin
      pos_q       <= pos_d;
      out_valid_q <= out_valid_d;
      out_char_q  <= out_char_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_char  = out_char_q;
  assign pos       = pos_q;

endmodule

// File: tb/tb_enigma_stream.sv
// Bench for enigma_stream: a one-rotor and a three-rotor instance, checked every
// cycle against a permutation/odometer model, plus hand-computed literals.
module tb_enigma_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        ld   [2];
  logic [39:0] lp   [2];
  logic        iv   [2];
  logic [7:0]  ic   [2];
  logic        ordy [2];

  logic        ir1, ov1, ir3, ov3;
  logic [7:0]  oc1, oc3;
  logic [4:0]  ps1;
  logic [14:0] ps3;

  enigma_stream #(.NUM_ROTORS(1)) u1 (
    .clk(clk), .rst(rst), .load(ld[0]), .load_pos(lp[0][4:0]),
    .in_valid(iv[0]), .in_ready(ir1), .in_char(ic[0]),
    .out_valid(ov1), .out_ready(ordy[0]), .out_char(oc1), .pos(ps1)
  );

  enigma_stream #(.NUM_ROTORS(3)) u3 (
    .clk(clk), .rst(rst), .load(ld[1]), .load_pos(lp[1][14:0]),
    .in_valid(iv[1]), .in_ready(ir3), .in_char(ic[1]),
    .out_valid(ov3), .out_ready(ordy[1]), .out_char(oc3), .pos(ps3)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int       mpos [2][8];
  logic     mv   [2];
  logic [7:0] mc [2];

  function automatic int nrot(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int md(input int v);
    return ((v % 26) + 26) % 26;
  endfunction

  function automatic int amul(input int i);
    case (i)
      0: return 3;   1: return 5;   2: return 7;   3: return 9;
      4: return 11;  5: return 15;  6: return 17;  default: return 19;
    endcase
  endfunction

  function automatic int fwd(input int i, input int p, input int x);
    return md(amul(i) * md(x + p) + i + 1 - p);
  endfunction

  // Backward path found by inverting each rotor's permutation by search.
  function automatic int model_enc(input int d, input int x);
    int y, found;
    y = x;
    for (int i = 0; i < nrot(d); i++) y = fwd(i, mpos[d][i], y);
    y = 25 - y;
    for (int i = nrot(d) - 1; i >= 0; i--) begin
      found = -1;
      for (int c = 0; c < 26; c++) if (fwd(i, mpos[d][i], c) == y) found = c;
      y = found;
    end
    return y;
  endfunction

  task automatic model_step(input int d);
    longint val, base;
    val = 0; base = 1;
    for (int i = 0; i < nrot(d); i++) begin
      val  += longint'(mpos[d][i]) * base;
      base *= 26;
    end
    val = (val + 1) % base;
    for (int i = 0; i < nrot(d); i++) begin
      mpos[d][i] = int'(val % 26);
      val        = val / 26;
    end
  endtask

  function automatic logic [39:0] mpack(input int d);
    logic [39:0] r;
    r = '0;
    for (int i = 0; i < nrot(d); i++) r[5*i +: 5] = 5'(mpos[d][i]);
    return r;
  endfunction

  always @(negedge clk) begin : compare
    logic        a_ir, a_ov, rdy;
    logic [7:0]  a_oc;
    logic [39:0] a_ps;
    int          f;
    for (int d = 0; d < 2; d++) begin
      a_ir = (d == 0) ? ir1 : ir3;
      a_ov = (d == 0) ? ov1 : ov3;
      a_oc = (d == 0) ? oc1 : oc3;
      a_ps = (d == 0) ? 40'(ps1) : 40'(ps3);
      if (rst) begin
        mv[d] = 1'b0;
        mc[d] = 8'h00;
        for (int i = 0; i < 8; i++) mpos[d][i] = 0;
      end
      rdy = !ld[d] && (!mv[d] || ordy[d]);
      chk($sformatf("d%0d_out_valid", d), 64'(a_ov), 64'(mv[d]));
      chk($sformatf("d%0d_pos", d), 64'(a_ps), 64'(mpack(d)));
      if (mv[d] || rst) chk($sformatf("d%0d_out_char", d), 64'(a_oc), 64'(mc[d]));
      if (!rst) begin
        chk($sformatf("d%0d_in_ready", d), 64'(a_ir), 64'(rdy));
        if (mv[d] && ordy[d]) mv[d] = 1'b0;
        if (ld[d]) begin
          for (int i = 0; i < nrot(d); i++) begin
            f = int'(lp[d][5*i +: 5]);
            mpos[d][i] = f % 26;
          end
        end else if (iv[d] && rdy) begin
          mv[d] = 1'b1;
          if (ic[d] >= 8'h41 && ic[d] <= 8'h5A) begin
            model_step(d);
            mc[d] = 8'(8'h41 + model_enc(d, int'(ic[d]) - 'h41));
          end else if (ic[d] >= 8'h61 && ic[d] <= 8'h7A) begin
            model_step(d);
            mc[d] = 8'(8'h61 + model_enc(d, int'(ic[d]) - 'h61));
          end else begin
            mc[d] = ic[d];
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input int d, input logic [7:0] ch);
    iv[d] = 1'b1; ic[d] = ch;
    @(posedge clk); #1;
    iv[d] = 1'b0;
  endtask

  task automatic load_p(input int d, input logic [39:0] v);
    ld[d] = 1'b1; lp[d] = v;
    @(posedge clk); #1;
    ld[d] = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  logic [14:0] p_hold;
  logic [7:0]  c_hold;

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      ld[d] = 1'b0; lp[d] = '0; iv[d] = 1'b0; ic[d] = 8'h00; ordy[d] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ov1", 64'(ov1), 0);
    chk("reset_oc1", 64'(oc1), 0);
    chk("reset_pos1", 64'(ps1), 0);
    chk("reset_ov3", 64'(ov3), 0);
    chk("reset_pos3", 64'(ps3), 0);
    rst = 1'b0;

    send(0, "A");
    chk("n1_A_first", 64'(oc1), 64'("P"));
    chk("n1_A_first_pos", 64'(ps1), 1);
    chk("n1_A_first_valid", 64'(ov1), 1);
    send(0, "A");
    chk("n1_A_second", 64'(oc1), 64'("F"));
    chk("n1_A_second_pos", 64'(ps1), 2);

    do_reset();
    send(0, "P");
    chk("inv_P", 64'(oc1), 64'("A"));
    do_reset();
    load_p(0, 40'd1);
    chk("load_pos1", 64'(ps1), 1);
    send(0, "F");
    chk("inv_F", 64'(oc1), 64'("A"));

    do_reset();
    send(0, "H");
    chk("case_H", 64'(oc1), 64'("I"));
    send(0, " ");
    chk("space_pass", 64'(oc1), 64'(" "));
    chk("space_no_step", 64'(ps1), 1);
    send(0, "h");
    chk("case_h", 64'(oc1), 64'("y"));
    chk("case_pos", 64'(ps1), 2);

    send(1, "H"); send(1, " "); send(1, "h"); send(1, "7");
    chk("n3_pass_pos", 64'(ps3), 2);
    chk("n3_digit", 64'(oc3), 64'("7"));

    load_p(1, {25'd0, 5'd0, 5'd25, 5'd25});
    send(1, "Q");
    chk("odometer", 64'(ps3), 64'({5'd1, 5'd0, 5'd0}));
    load_p(1, 40'd30);
    chk("load_30", 64'(ps3), 4);
    load_p(1, {25'd0, 5'd31, 5'd27, 5'd3});
    chk("load_mixed", 64'(ps3), 64'({5'd5, 5'd1, 5'd3}));

    @(posedge clk); #1;
    ordy[1] = 1'b0; iv[1] = 1'b1; ic[1] = "K";
    @(posedge clk); #1;
    p_hold = ps3; c_hold = oc3;
    chk("bp_first_pos", 64'(ps3), 64'({5'd5, 5'd1, 5'd4}));
    ic[1] = "M";
    repeat (4) begin
      @(posedge clk); #1;
      chk("bp_in_ready", 64'(ir3), 0);
      chk("bp_pos_frozen", 64'(ps3), 64'(p_hold));
      chk("bp_char_stable", 64'(oc3), 64'(c_hold));
      chk("bp_valid", 64'(ov3), 1);
    end
    ordy[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ic[1] = 8'(8'h61 + k);
      @(posedge clk); #1;
      chk("stream_valid", 64'(ov3), 1);
    end
    iv[1] = 1'b0;
    chk("stream_pos", 64'(ps3), 64'({5'd5, 5'd1, 5'd8}));

    @(posedge clk); #1;
    ordy[1] = 1'b0;
    send(1, "Z");
    chk("pre_reset_valid", 64'(ov3), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ov", 64'(ov3), 0);
    chk("async_rst_oc", 64'(oc3), 0);
    chk("async_rst_pos3", 64'(ps3), 0);
    chk("async_rst_pos1", 64'(ps1), 0);
    @(posedge clk); #1 rst = 1'b0;
    ordy[1] = 1'b1;
    send(1, "A");
    send(0, "A");
    chk("post_reset_n1", 64'(oc1), 64'("P"));
    repeat (2) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
